// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate formats, opcodes and immediate builder
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_J   = 3'b011,
        FMT_U   = 3'b100,
        FMT_Z   = 3'b101,
        FMT_SH  = 3'b110,
        FMT_RSV = 3'b111
    } imm_fmt_e;

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_ONE   = 2'b01,
        SLOT_TWO   = 2'b10
    } slot_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 values that make an OP-IMM instruction a shift (slli/srli/srai)
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    // Builds the 64-bit immediate; callers truncate to XLEN. wide_sh selects
    // the 6-bit shamt field used by 64-bit shifts.
    function automatic logic [63:0] build_imm(input logic [31:0] instr,
                                              input imm_fmt_e   fmt,
                                              input logic       wide_sh);
        logic s;
        s = instr[31];
        case (fmt)
            FMT_I:   return {{52{s}}, instr[31:20]};
            FMT_S:   return {{52{s}}, instr[31:25], instr[11:7]};
            FMT_B:   return {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   return {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   return {{32{s}}, instr[31:12], 12'b0};
            FMT_Z:   return {59'b0, instr[19:15]};
            FMT_SH:  return wide_sh ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            default: return 64'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_immsrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_immsrc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_immsrc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - 2-entry valid/ready register slice with skid entry
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    slot_e        state, state_n;
    logic [W-1:0] skid_data;
    logic         load_out, load_skid, move_skid;
    logic         accept;

    // Both handshake outputs come straight from state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state != SLOT_TWO);
    assign out_valid = (state != SLOT_EMPTY);
    assign accept    = in_valid && in_ready;

    // Next occupancy and which register loads; flush overrides everything.
    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_n  = SLOT_ONE;
                end
            end
            SLOT_ONE: begin
                if (out_ready) begin
                    if (accept) begin
                        load_out = 1'b1;
                    end else begin
                        state_n = SLOT_EMPTY;
                    end
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = SLOT_TWO;
                end
            end
            SLOT_TWO: begin
                if (out_ready) begin
                    move_skid = 1'b1;
                    state_n   = SLOT_ONE;
                end
            end
            default: state_n = SLOT_EMPTY;
        endcase
        if (flush) begin
            state_n   = SLOT_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    // Occupancy register and the two data entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SLOT_EMPTY;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state <= state_n;
            if (load_out) begin
                out_data <= in_data;
            end else if (move_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with PC-relative target
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    imm_gen_pipe_if.slave bus
);

    localparam int W = 2 * XLEN + 4;

    imm_fmt_e        fmt_c;
    logic            wide_sh_c;
    logic            ill_c;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] tgt_c;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [W-1:0]    out_data;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];

    // Resolve the immediate format from the opcode or the explicit selector.
    always_comb begin
        fmt_c     = FMT_RSV;
        wide_sh_c = (XLEN == 64);
        if (AUTO_DECODE) begin
            case (opcode)
                OPC_LOAD, OPC_JALR: fmt_c = FMT_I;
                OPC_OP_IMM:         fmt_c = is_shift_f3(funct3) ? FMT_SH : FMT_I;
                OPC_OP_IMM_32: begin
                    // word shifts only take a 5-bit shamt
                    wide_sh_c = 1'b0;
                    if (XLEN == 64) begin
                        fmt_c = is_shift_f3(funct3) ? FMT_SH : FMT_I;
                    end
                end
                OPC_STORE:           fmt_c = FMT_S;
                OPC_BRANCH:          fmt_c = FMT_B;
                OPC_JAL:             fmt_c = FMT_J;
                OPC_LUI, OPC_AUIPC:  fmt_c = FMT_U;
                OPC_SYSTEM:          fmt_c = funct3[2] ? FMT_Z : FMT_I;
                default:             fmt_c = FMT_RSV;
            endcase
        end else begin
            fmt_c = imm_fmt_e'(bus.in_immsrc);
        end
    end

    assign ill_c = (fmt_c == FMT_RSV);
    assign imm_c = XLEN'(build_imm(bus.in_instr, fmt_c, wide_sh_c));
    assign tgt_c = bus.in_pc + imm_c;

    imm_skid_buf #(
        .W(W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({imm_c, tgt_c, fmt_c, ill_c}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign bus.out_imm     = out_data[W-1 -: XLEN];
    assign bus.out_target  = out_data[XLEN+3 -: XLEN];
    assign bus.out_fmt     = out_data[3:1];
    assign bus.out_illegal = out_data[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  src;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  immsrc;

    int checks   = 0;
    int failures = 0;

    int cfg_xlen[3] = '{32, 64, 64};
    bit cfg_auto[3] = '{1'b1, 1'b1, 1'b0};

    beat_t q[$];

    logic        o_valid[3], in_rdy[3], o_ill[3];
    logic [63:0] o_imm[3], o_tgt[3];
    logic [2:0]  o_fmt[3];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b0 ();
    imm_gen_pipe_if #(.XLEN(64)) b1 ();
    imm_gen_pipe_if #(.XLEN(64)) b2 ();

    assign b0.flush = flush;  assign b1.flush = flush;  assign b2.flush = flush;
    assign b0.in_valid = in_valid; assign b1.in_valid = in_valid; assign b2.in_valid = in_valid;
    assign b0.in_instr = instr; assign b1.in_instr = instr; assign b2.in_instr = instr;
    assign b0.in_pc = pc[31:0]; assign b1.in_pc = pc; assign b2.in_pc = pc;
    assign b0.in_immsrc = immsrc; assign b1.in_immsrc = immsrc; assign b2.in_immsrc = immsrc;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready; assign b2.out_ready = out_ready;

    assign o_valid[0] = b0.out_valid; assign o_valid[1] = b1.out_valid; assign o_valid[2] = b2.out_valid;
    assign in_rdy[0] = b0.in_ready; assign in_rdy[1] = b1.in_ready; assign in_rdy[2] = b2.in_ready;
    assign o_imm[0] = {32'b0, b0.out_imm}; assign o_imm[1] = b1.out_imm; assign o_imm[2] = b2.out_imm;
    assign o_tgt[0] = {32'b0, b0.out_target}; assign o_tgt[1] = b1.out_target; assign o_tgt[2] = b2.out_target;
    assign o_fmt[0] = b0.out_fmt; assign o_fmt[1] = b1.out_fmt; assign o_fmt[2] = b2.out_fmt;
    assign o_ill[0] = b0.out_illegal; assign o_ill[1] = b1.out_illegal; assign o_ill[2] = b2.out_illegal;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u_dut32 (.clk(clk), .reset(reset), .bus(b0));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_dut64 (.clk(clk), .reset(reset), .bus(b1));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0)) u_dut64x (.clk(clk), .reset(reset), .bus(b2));

    // Reference: immediate value from the instruction-set rules using arithmetic shifts.
    function automatic exp_t model(input int xlen, input bit auto_dec, input beat_t b);
        exp_t        e;
        int          f, sh_bits;
        longint      s, v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] mask;
        op = b.instr[6:0];
        f3 = b.instr[14:12];
        s  = longint'($signed(b.instr));
        if (auto_dec) begin
            case (op)
                7'h03, 7'h67: f = 0;
                7'h13:        f = (f3 == 1 || f3 == 5) ? 6 : 0;
                7'h1B:        f = (xlen == 64) ? ((f3 == 1 || f3 == 5) ? 6 : 0) : 7;
                7'h23:        f = 1;
                7'h63:        f = 2;
                7'h6F:        f = 3;
                7'h37, 7'h17: f = 4;
                7'h73:        f = f3[2] ? 5 : 0;
                default:      f = 7;
            endcase
        end else begin
            f = int'(b.src);
        end
        sh_bits = (xlen == 64 && !(auto_dec && op == 7'h1B)) ? 6 : 5;
        case (f)
            0: v = s >>> 20;
            1: v = ((s >>> 25) << 5) | longint'(b.instr[11:7]);
            2: v = ((s >>> 31) << 12) | (longint'(b.instr[7]) << 11)
                   | (longint'(b.instr[30:25]) << 5) | (longint'(b.instr[11:8]) << 1);
            3: v = ((s >>> 31) << 20) | (longint'(b.instr[19:12]) << 12)
                   | (longint'(b.instr[20]) << 11) | (longint'(b.instr[30:21]) << 1);
            4: v = (s >>> 12) << 12;
            5: v = longint'(b.instr >> 15) % 32;
            6: v = longint'(b.instr >> 20) % (longint'(1) << sh_bits);
            default: begin v = 0; f = 7; end
        endcase
        mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.imm = 64'(v) & mask;
        e.tgt = (b.pc + 64'(v)) & mask;
        e.fmt = 3'(f);
        e.ill = (f == 7);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: compare all DUTs at the negedge, then advance the occupancy model.
    task automatic cycle();
        exp_t  e;
        beat_t b;
        bit    acc, drn;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_ready[%0d]", d), 64'(in_rdy[d]), 64'(q.size() < 2));
            chk($sformatf("out_valid[%0d]", d), 64'(o_valid[d]), 64'(q.size() > 0));
            if (q.size() > 0) begin
                e = model(cfg_xlen[d], cfg_auto[d], q[0]);
                chk($sformatf("imm[%0d]", d), o_imm[d], e.imm);
                chk($sformatf("target[%0d]", d), o_tgt[d], e.tgt);
                chk($sformatf("fmt[%0d]", d), 64'(o_fmt[d]), 64'(e.fmt));
                chk($sformatf("illegal[%0d]", d), 64'(o_ill[d]), 64'(e.ill));
            end
        end
        acc = in_valid && (q.size() < 2) && !flush && !reset;
        drn = (q.size() > 0) && out_ready && !flush && !reset;
        b.instr = instr; b.pc = pc; b.src = immsrc;
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] i, input logic [63:0] p, input logic [2:0] s);
        in_valid = 1'b1; instr = i; pc = p; immsrc = s;
    endtask

    logic [63:0] snap;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; immsrc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid[%0d]", d), 64'(o_valid[d]), 64'd0);
            chk($sformatf("rst_ready[%0d]", d), 64'(in_rdy[d]), 64'd1);
            chk($sformatf("rst_imm[%0d]", d), o_imm[d], 64'd0);
            chk($sformatf("rst_tgt[%0d]", d), o_tgt[d], 64'd0);
            chk($sformatf("rst_fmt[%0d]", d), 64'(o_fmt[d]), 64'd0);
            chk($sformatf("rst_ill[%0d]", d), 64'(o_ill[d]), 64'd0);
        end

        // Directed single beats, checked 1 cycle after accept.
        offer(32'hFFF0_0093, 64'h0, 3'd0); cycle(); in_valid = 1'b0;
        chk("addi_valid", 64'(o_valid[0]), 64'd1);
        chk("addi_imm", o_imm[0], 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(o_fmt[0]), 64'd0);
        chk("addi_imm64", o_imm[1], 64'hFFFF_FFFF_FFFF_FFFF);
        offer(32'h1234_50B7, 64'h0, 3'd4); cycle(); in_valid = 1'b0;
        chk("lui_imm", o_imm[0], 64'h1234_5000);
        chk("lui_fmt", 64'(o_fmt[0]), 64'd4);
        offer(32'hFE00_0EE3, 64'h100, 3'd2); cycle(); in_valid = 1'b0;
        chk("br_imm", o_imm[0], 64'hFFFF_FFFC);
        chk("br_tgt", o_tgt[0], 64'h0000_00FC);
        offer(32'h0080_006F, 64'h200, 3'd3); cycle(); in_valid = 1'b0;
        chk("jal_imm", o_imm[0], 64'd8);
        chk("jal_tgt", o_tgt[0], 64'h208);
        offer(32'h4030_D093, 64'h0, 3'd6); cycle(); in_valid = 1'b0;
        chk("srai_imm", o_imm[0], 64'd3);
        chk("srai_fmt", 64'(o_fmt[0]), 64'd6);
        offer(32'h300F_D073, 64'h0, 3'd5); cycle(); in_valid = 1'b0;
        chk("csrrwi_imm", o_imm[0], 64'h1F);
        chk("csrrwi_fmt", 64'(o_fmt[0]), 64'd5);
        offer(32'h0000_007F, 64'h40, 3'd7); cycle(); in_valid = 1'b0;
        chk("bad_ill", 64'(o_ill[0]), 64'd1);
        chk("bad_imm", o_imm[0], 64'd0);
        chk("bad_fmt", 64'(o_fmt[0]), 64'd7);
        chk("expl_ill", 64'(o_ill[2]), 64'd1);
        offer(32'h8000_02B7, 64'h0, 3'd4); cycle(); in_valid = 1'b0;
        chk("lui64_imm", o_imm[1], 64'hFFFF_FFFF_8000_0000);
        offer(32'h03F0_9093, 64'h0, 3'd6); cycle(); in_valid = 1'b0;
        chk("slli64_imm", o_imm[1], 64'd63);
        chk("slli32_imm", o_imm[0], 64'd31);
        offer(32'h03F0_909B, 64'h0, 3'd6); cycle(); in_valid = 1'b0;
        chk("slliw_imm", o_imm[1], 64'd31);
        chk("slliw32_ill", 64'(o_ill[0]), 64'd1);
        cycle();

        // Backpressure: A held, B in skid, C stalls, then A,B,C back-to-back.
        out_ready = 1'b0;
        offer(32'h0010_0093, 64'h0, 3'd0); cycle();
        snap = o_imm[0];
        offer(32'h0020_0093, 64'h0, 3'd0); cycle();
        chk("bp_hold1", o_imm[0], snap);
        chk("bp_ready0", 64'(in_rdy[0]), 64'd0);
        offer(32'h0030_0093, 64'h0, 3'd0); cycle();
        chk("bp_hold2", o_imm[0], 64'd1);
        chk("bp_ready0b", 64'(in_rdy[0]), 64'd0);
        out_ready = 1'b1; cycle();
        chk("bp_B", o_imm[0], 64'd2);
        chk("bp_B_valid", 64'(o_valid[0]), 64'd1);
        cycle(); in_valid = 1'b0;
        chk("bp_C", o_imm[0], 64'd3);
        cycle();
        chk("bp_empty", 64'(o_valid[0]), 64'd0);

        // Flush then reset with two beats held and a new beat offered.
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b0;
            offer(32'h0050_0093, 64'h0, 3'd0); cycle();
            offer(32'h0060_0093, 64'h0, 3'd0); cycle();
            offer(32'h0070_0093, 64'h0, 3'd0);
            if (k == 0) flush = 1'b1; else reset = 1'b1;
            cycle();
            flush = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            chk($sformatf("drop_valid%0d", k), 64'(o_valid[0]), 64'd0);
            chk($sformatf("drop_ready%0d", k), 64'(in_rdy[0]), 64'd1);
            cycle();
            chk($sformatf("drop_lost%0d", k), 64'(o_valid[0]), 64'd0);
        end
        chk("rst_imm_after", o_imm[0], 64'd0);

        // Randomized traffic with backpressure and occasional flush.
        begin
            logic [6:0] ops[12];
            ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                    7'h37, 7'h17, 7'h73, 7'h33, 7'h7F};
            for (int n = 0; n < 400; n++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
                flush     = ($urandom_range(0, 39) == 0);
                instr     = {$urandom() & 32'hFFFF_FF80};
                instr[6:0] = ops[$urandom_range(0, 11)];
                pc        = {$urandom(), $urandom()};
                immsrc    = 3'($urandom_range(0, 7));
                cycle();
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        chk("final_empty", 64'(o_valid[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
